// File: rtl/dmem_port_arbiter_pkg.sv
// +--------------------------------------------------------------------+
// | dmem_arb_pkg : shared types and constants for dmem_port_arbiter     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package dmem_arb_pkg;

  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_EXT  = 2'd2
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/dmem_port_arbiter_if.sv
// +--------------------------------------------------------------------+
// | dmem_port_arbiter_if : core, host and memory signals of the arbiter |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface dmem_port_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);

  logic              core_req;
  logic              core_wen;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_stall;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  logic              ext_req;
  logic              ext_wen;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic              mem_ren;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  core_req, core_wen, core_addr, core_wdata,
    output core_gnt, core_stall, core_rvalid, core_rdata,
    input  ext_req, ext_wen, ext_addr, ext_wdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_addr, mem_wen, mem_ren, mem_wdata,
    input  mem_rdata
  );

  // Requester / memory side
  modport master (
    output core_req, core_wen, core_addr, core_wdata,
    input  core_gnt, core_stall, core_rvalid, core_rdata,
    output ext_req, ext_wen, ext_addr, ext_wdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_addr, mem_wen, mem_ren, mem_wdata,
    output mem_rdata
  );

endinterface

`default_nettype wire

// File: rtl/dmem_port_arbiter_starve_cnt.sv
// +--------------------------------------------------------------------+
// | dmem_arb_starve_cnt : saturating counter of contested core grants   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module dmem_arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  wire logic clk,
  input  wire logic arst_n,
  input  wire logic inc,
  input  wire logic clr,
  output logic      starve_hit
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;

  // Clear has priority so a host grant always restarts the window.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve_hit = (cnt_q == LIMIT_C);

endmodule

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// +--------------------------------------------------------------------+
// | dmem_port_arbiter : core/host sharing of the single-port data SRAM  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic           clk,
  input  wire logic           arst_n,
  dmem_port_arbiter_if.slave  bus
);

  logic   core_gnt;
  logic   ext_gnt;
  logic   starve_hit;
  owner_t rd_owner_q;
  owner_t rd_owner_d;

  dmem_arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk        (clk),
    .arst_n     (arst_n),
    .inc        (core_gnt & bus.ext_req),
    .clr        (ext_gnt | ~bus.ext_req),
    .starve_hit (starve_hit)
  );

  always_comb begin
    core_gnt = 1'b0;
    ext_gnt  = 1'b0;
    if (bus.core_req && bus.ext_req) begin
      if (starve_hit) begin
        ext_gnt = 1'b1;
      end else begin
        core_gnt = 1'b1;
      end
    end else if (bus.core_req) begin
      core_gnt = 1'b1;
    end else if (bus.ext_req) begin
      ext_gnt = 1'b1;
    end
  end

  // Memory bus is forced to zero when idle so the SRAM sees no stale address.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wen   = 1'b0;
    bus.mem_ren   = 1'b0;
    rd_owner_d    = OWN_NONE;
    if (core_gnt) begin
      bus.mem_addr  = bus.core_addr;
      bus.mem_wdata = bus.core_wdata;
      bus.mem_wen   = bus.core_wen;
      bus.mem_ren   = ~bus.core_wen;
      rd_owner_d    = bus.core_wen ? OWN_NONE : OWN_CORE;
    end else if (ext_gnt) begin
      bus.mem_addr  = bus.ext_addr;
      bus.mem_wdata = bus.ext_wdata;
      bus.mem_wen   = bus.ext_wen;
      bus.mem_ren   = ~bus.ext_wen;
      rd_owner_d    = bus.ext_wen ? OWN_NONE : OWN_EXT;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_owner_q <= OWN_NONE;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  assign bus.core_gnt    = core_gnt;
  assign bus.ext_gnt     = ext_gnt;
  assign bus.core_stall  = bus.core_req & ~core_gnt;
  assign bus.core_rvalid = (rd_owner_q == OWN_CORE);
  assign bus.ext_rvalid  = (rd_owner_q == OWN_EXT);
  assign bus.core_rdata  = bus.mem_rdata;
  assign bus.ext_rdata   = bus.mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_dmem_port_arbiter : directed scoreboard bench for the arbiter    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_dmem_port_arbiter;
  import dmem_arb_pkg::*;

  typedef struct {
    owner_t      own;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        arst_n;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [63:0] sram    [256];
  logic [63:0] ref_mem [256];

  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.DATA_W(64), .ADDR_W(64)) bus ();

  dmem_port_arbiter #(
    .DATA_W       (64),
    .ADDR_W       (64),
    .STARVE_LIMIT (4)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus.slave)
  );

  // 1-cycle-latency SRAM model
  always @(posedge clk) begin
    if (bus.mem_wen) sram[bus.mem_addr[10:3]] <= bus.mem_wdata;
    if (bus.mem_ren) bus.mem_rdata <= sram[bus.mem_addr[10:3]];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.core_req = 1'b0; bus.core_wen = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.ext_req  = 1'b0; bus.ext_wen  = 1'b0; bus.ext_addr  = '0; bus.ext_wdata  = '0;
  endtask

  task automatic step(input logic cr, input logic cw, input logic [63:0] ca, input logic [63:0] cd,
                      input logic er, input logic ew, input logic [63:0] ea, input logic [63:0] ed,
                      input logic xc, input logic xe);
    exp_t        e;
    exp_t        n;
    logic [63:0] x_addr;
    logic [63:0] x_wdata;
    logic        x_wen;
    logic        x_ren;
    bus.core_req = cr; bus.core_wen = cw; bus.core_addr = ca; bus.core_wdata = cd;
    bus.ext_req  = er; bus.ext_wen  = ew; bus.ext_addr  = ea; bus.ext_wdata  = ed;
    @(negedge clk);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '{OWN_NONE, 64'h0};
    chk("core_rvalid", 64'(bus.core_rvalid), 64'(e.own == OWN_CORE));
    chk("ext_rvalid", 64'(bus.ext_rvalid), 64'(e.own == OWN_EXT));
    if (e.own == OWN_CORE) chk("core_rdata", bus.core_rdata, e.data);
    if (e.own == OWN_EXT)  chk("ext_rdata", bus.ext_rdata, e.data);
    chk("core_gnt", 64'(bus.core_gnt), 64'(xc));
    chk("ext_gnt", 64'(bus.ext_gnt), 64'(xe));
    chk("core_stall", 64'(bus.core_stall), 64'(cr & ~xc));
    x_addr  = xc ? ca : (xe ? ea : 64'h0);
    x_wdata = xc ? cd : (xe ? ed : 64'h0);
    x_wen   = (xc & cw) | (xe & ew);
    x_ren   = (xc & ~cw) | (xe & ~ew);
    chk("mem_addr", bus.mem_addr, x_addr);
    chk("mem_wdata", bus.mem_wdata, x_wdata);
    chk("mem_wen", 64'(bus.mem_wen), 64'(x_wen));
    chk("mem_ren", 64'(bus.mem_ren), 64'(x_ren));
    n.own  = (xc & ~cw) ? OWN_CORE : ((xe & ~ew) ? OWN_EXT : OWN_NONE);
    n.data = ref_mem[x_addr[10:3]];
    exp_q.push_back(n);
    if (x_wen) ref_mem[x_addr[10:3]] = x_wdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i]    <= 64'h0;
      ref_mem[i] = 64'h0;
    end
    sram[2]    <= 64'hA5;
    ref_mem[2] = 64'hA5;
    idle_inputs();
    arst_n = 1'b0;
    #12;
    chk("rst_core_rvalid", 64'(bus.core_rvalid), 64'h0);
    chk("rst_ext_rvalid", 64'(bus.ext_rvalid), 64'h0);
    chk("rst_core_gnt", 64'(bus.core_gnt), 64'h0);
    chk("rst_ext_gnt", 64'(bus.ext_gnt), 64'h0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;

    // core read of preloaded word
    step(1, 0, 64'h10, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // host write then read-back
    step(0, 0, 0, 0, 1, 1, 64'h20, 64'hDEAD, 0, 1);
    step(0, 0, 0, 0, 1, 0, 64'h20, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // continuous contention: core x4 then host, then core again
    for (int i = 0; i < 4; i++)
      step(1, 1, 64'h40 + 64'(8 * i), 64'h100 + 64'(i), 1, 0, 64'h10, 0, 1, 0);
    step(1, 1, 64'h60, 64'h104, 1, 0, 64'h10, 0, 0, 1);
    step(1, 1, 64'h60, 64'h104, 1, 0, 64'h20, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // host drops its request mid-window: counter restarts
    step(1, 1, 64'h68, 64'h200, 1, 0, 64'h20, 0, 1, 0);
    step(1, 1, 64'h70, 64'h201, 1, 0, 64'h20, 0, 1, 0);
    step(1, 1, 64'h78, 64'h202, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      step(1, 0, 64'h10, 0, 1, 0, 64'h20, 0, 1, 0);
    step(1, 0, 64'h10, 0, 1, 0, 64'h20, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // core read then host read on consecutive cycles
    step(1, 0, 64'h10, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0, 64'h20, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset right after a granted host read drops its return
    step(0, 0, 0, 0, 1, 0, 64'h40, 0, 0, 1);
    arst_n = 1'b0;
    idle_inputs();
    #1;
    chk("arst_ext_rvalid", 64'(bus.ext_rvalid), 64'h0);
    chk("arst_core_rvalid", 64'(bus.core_rvalid), 64'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      step(1, 0, 64'h10, 0, 1, 0, 64'h20, 0, 1, 0);
    step(1, 0, 64'h10, 0, 1, 0, 64'h20, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
